usrt_core: RTL and testbench

- Synchronous serial (USRT) transmitter plus receiver pair sharing one clock; one serial bit per clock cycle, no baud divider.
- Frame: start bit 0, DATA_BITS data bits LSB first, stop bit 1; the line idles high.
- The TX and RX halves are independent. The system (or bench) links them by wiring o_Tx_Serial to i_Rx_Serial.
- Sits between byte-level logic and a single-wire link whose two ends share the same clock.

---
 rtl/usrt_core.sv | 233 +++++++++++++++++++++++
 tb/tb_usrt_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_core.sv
// Synchronous serial transmitter/receiver pair, one bit per clock, start/LSB-first data/stop framing.
// Define USRT_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module usrt_core #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic                 i_Tx_DV,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Frame_Err
);

    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop,
        TxCleanup
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxData,
        RxParity,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    // ------------------------------------------------------------------ transmitter
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
    logic [IdxW-1:0]      tx_idx_nxt;
    logic                 tx_serial_q, tx_serial_d;
    logic                 tx_done_q, tx_done_d;

    assign tx_idx_nxt = tx_idx_q + 1'b1;

    // The line register is loaded with the value for the state being entered,
    // so o_Tx_Serial always lines up with the current state.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        tx_idx_d    = tx_idx_q;
        tx_serial_d = tx_serial_q;
        tx_done_d   = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_serial_d = 1'b1;
                if (i_Tx_DV) begin
                    tx_data_d   = i_Tx_Byte;
                    tx_idx_d    = '0;
                    tx_serial_d = 1'b0;
                    tx_state_d  = TxStart;
                end
            end
            TxStart: begin
                tx_idx_d    = '0;
                tx_serial_d = tx_data_q[0];
                tx_state_d  = TxData;
            end
            TxData: begin
                if (tx_idx_q == LastIdx) begin
`ifdef USRT_PARITY_EN
                    tx_serial_d = ^tx_data_q;
                    tx_state_d  = TxParity;
`else
                    tx_serial_d = 1'b1;
                    tx_state_d  = TxStop;
`endif
                end else begin
                    tx_idx_d    = tx_idx_nxt;
                    tx_serial_d = tx_data_q[tx_idx_nxt];
                end
            end
            TxParity: begin
                tx_serial_d = 1'b1;
                tx_state_d  = TxStop;
            end
            TxStop: begin
                tx_serial_d = 1'b1;
                tx_done_d   = 1'b1;
                tx_state_d  = TxCleanup;
            end
            TxCleanup: begin
                tx_serial_d = 1'b1;
                tx_state_d  = TxIdle;
            end
            default: begin
                tx_serial_d = 1'b1;
                tx_state_d  = TxIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            tx_state_q  <= TxIdle;
            tx_data_q   <= '0;
            tx_idx_q    <= '0;
            tx_serial_q <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_data_q   <= tx_data_d;
            tx_idx_q    <= tx_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign o_Tx_Serial = tx_serial_q;
    assign o_Tx_Done   = tx_done_q;
    assign o_Tx_Active = (tx_state_q != TxIdle) && (tx_state_q != TxCleanup);

    // ------------------------------------------------------------------ receiver
    rx_state_e            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 rx_err_q, rx_err_d;
`ifdef USRT_PARITY_EN
    logic                 rx_par_err_q, rx_par_err_d;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        rx_err_d   = 1'b0;
`ifdef USRT_PARITY_EN
        rx_par_err_d = rx_par_err_q;
`endif
        unique case (rx_state_q)
            RxIdle: begin
                if (!i_Rx_Serial) begin
                    rx_idx_d   = '0;
                    rx_state_d = RxData;
                end
            end
            RxData: begin
                rx_shift_d[rx_idx_q] = i_Rx_Serial;
                if (rx_idx_q == LastIdx) begin
`ifdef USRT_PARITY_EN
                    rx_state_d = RxParity;
`else
                    rx_state_d = RxStop;
`endif
                end else begin
                    rx_idx_d = rx_idx_q + 1'b1;
                end
            end
            RxParity: begin
`ifdef USRT_PARITY_EN
                rx_par_err_d = (i_Rx_Serial != ^rx_shift_q);
`endif
                rx_state_d = RxStop;
            end
            RxStop: begin
                if (i_Rx_Serial) begin
`ifdef USRT_PARITY_EN
                    if (rx_par_err_q) begin
                        rx_err_d = 1'b1;
                    end else begin
                        rx_byte_d = rx_shift_q;
                        rx_dv_d   = 1'b1;
                    end
`else
                    rx_byte_d = rx_shift_q;
                    rx_dv_d   = 1'b1;
`endif
                    rx_state_d = RxIdle;
                end else begin
                    // A low stop bit may be a break; wait for the line to recover.
                    rx_err_d   = 1'b1;
                    rx_state_d = RxWaitHigh;
                end
            end
            RxWaitHigh: begin
                if (i_Rx_Serial) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_state_q <= RxIdle;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
            rx_err_q   <= rx_err_d;
        end
    end

`ifdef USRT_PARITY_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_par_err_q <= 1'b0;
        end else begin
            rx_par_err_q <= rx_par_err_d;
        end
    end
`endif

    assign o_Rx_DV        = rx_dv_q;
    assign o_Rx_Byte      = rx_byte_q;
    assign o_Rx_Frame_Err = rx_err_q;

endmodule

// File: tb/tb_usrt_core.sv
// Directed bench for usrt_core: reset, loopback frames, back-to-back, framing error, mid-frame reset.
// Parity steps are included when USRT_PARITY_EN is defined.
module tb_usrt_core;

    localparam int unsigned DATA_BITS = 8;
`ifdef USRT_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned FRAME = DATA_BITS + 2 + PAR;

    logic                 r_Clock = 1'b0;
    logic                 r_Reset;
    logic [DATA_BITS-1:0] r_Tx_Byte;
    logic                 r_Tx_DV;
    logic                 r_Loop;
    logic                 r_Rx_Drive;
    logic                 w_Tx_Serial;
    logic                 w_Tx_Active;
    logic                 w_Tx_Done;
    logic                 w_Rx_Serial;
    logic                 w_Rx_DV;
    logic [DATA_BITS-1:0] w_Rx_Byte;
    logic                 w_Rx_Frame_Err;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    assign w_Rx_Serial = r_Loop ? w_Tx_Serial : r_Rx_Drive;

    always #5 r_Clock = ~r_Clock;

    usrt_core #(.DATA_BITS(DATA_BITS)) dut (
        .i_Clock       (r_Clock),
        .i_Reset       (r_Reset),
        .i_Tx_Byte     (r_Tx_Byte),
        .i_Tx_DV       (r_Tx_DV),
        .o_Tx_Serial   (w_Tx_Serial),
        .o_Tx_Active   (w_Tx_Active),
        .o_Tx_Done     (w_Tx_Done),
        .i_Rx_Serial   (w_Rx_Serial),
        .o_Rx_DV       (w_Rx_DV),
        .o_Rx_Byte     (w_Rx_Byte),
        .o_Rx_Frame_Err(w_Rx_Frame_Err)
    );

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge r_Clock) begin
        #2;
        if (w_Rx_DV) dv_cnt++;
        if (w_Rx_Frame_Err) err_cnt++;
        if (w_Tx_Done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge r_Clock);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            step(1);
            if (w_Tx_Done) seen = 1'b1;
        end
    endtask

    task automatic wait_rx_dv(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            step(1);
            if (w_Rx_DV) seen = 1'b1;
        end
    endtask

    // Drive a frame straight onto the receiver input, one bit per cycle.
    task automatic send_direct(input logic [DATA_BITS-1:0] data, input logic par,
                               input logic stop);
        r_Rx_Drive = 1'b0;
        step(1);
        for (int i = 0; i < DATA_BITS; i++) begin
            r_Rx_Drive = data[i];
            step(1);
        end
        if (PAR != 0) begin
            r_Rx_Drive = par;
            step(1);
        end
        r_Rx_Drive = stop;
        step(1);
    endtask

    initial begin
        logic [FRAME-1:0] seq;
        int dv0, err0, done0;
        bit seen;

        r_Reset    = 1'b1;
        r_Tx_DV    = 1'b0;
        r_Tx_Byte  = '0;
        r_Loop     = 1'b1;
        r_Rx_Drive = 1'b1;
        step(2);
        check("rst_tx_serial", w_Tx_Serial, 1);
        check("rst_tx_active", w_Tx_Active, 0);
        check("rst_tx_done", w_Tx_Done, 0);
        check("rst_rx_dv", w_Rx_DV, 0);
        check("rst_rx_byte", w_Rx_Byte, 0);
        check("rst_rx_err", w_Rx_Frame_Err, 0);
        r_Reset = 1'b0;
        step(2);

        // Loopback 0x5B: start, 1,1,0,1,1,0,1,0, [parity 1], stop
`ifdef USRT_PARITY_EN
        seq = 11'b11010110110;
`else
        seq = 10'b1010110110;
`endif
        dv0 = dv_cnt;
        done0 = done_cnt;
        r_Tx_Byte = 8'h5B;
        r_Tx_DV = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            step(1);
            check($sformatf("lb_bit%0d", k), w_Tx_Serial, seq[k]);
            if (k == 0) check("lb_active", w_Tx_Active, 1);
        end
        check("lb_done_early", w_Tx_Done, 0);
        step(1);
        check("lb_done", w_Tx_Done, 1);
        check("lb_rx_dv", w_Rx_DV, 1);
        check("lb_rx_byte", w_Rx_Byte, 8'h5B);
        check("lb_active_clr", w_Tx_Active, 0);
        r_Tx_DV = 1'b0;
        step(1);
        check("lb_done_clr", w_Tx_Done, 0);
        check("lb_idle_line", w_Tx_Serial, 1);
        step(3);
        check("lb_dv_count", dv_cnt - dv0, 1);
        check("lb_done_count", done_cnt - done0, 1);

        // Back-to-back frames with DV held high
        dv0 = dv_cnt;
        done0 = done_cnt;
        r_Tx_Byte = 8'h00;
        r_Tx_DV = 1'b1;
        wait_done(seen);
        check("b2b_done1", seen, 1);
        check("b2b_byte1", w_Rx_Byte, 8'h00);
        r_Tx_Byte = 8'hFF;
        step(1);
        wait_done(seen);
        check("b2b_done2", seen, 1);
        check("b2b_byte2", w_Rx_Byte, 8'hFF);
        r_Tx_DV = 1'b0;
        step(4);
        check("b2b_dv_count", dv_cnt - dv0, 2);
        check("b2b_done_count", done_cnt - done0, 2);

        // Direct RX: 0xA5 with stop bit 0, then line held low
        r_Loop = 1'b0;
        r_Rx_Drive = 1'b1;
        step(2);
        dv0 = dv_cnt;
        err0 = err_cnt;
        send_direct(8'hA5, 1'b0, 1'b0);
        check("ferr_pulse", w_Rx_Frame_Err, 1);
        check("ferr_no_dv", w_Rx_DV, 0);
        step(5);
        check("ferr_clr", w_Rx_Frame_Err, 0);
        check("ferr_count_low", err_cnt - err0, 1);
        check("ferr_byte_kept", w_Rx_Byte, 8'hFF);
        r_Rx_Drive = 1'b1;
        step(3);
        check("ferr_count_high", err_cnt - err0, 1);
        check("ferr_dv_count", dv_cnt - dv0, 0);

        // Byte changed after capture
        r_Loop = 1'b1;
        step(1);
        dv0 = dv_cnt;
        r_Tx_Byte = 8'h3C;
        r_Tx_DV = 1'b1;
        step(1);
        r_Tx_Byte = 8'hC3;
        r_Tx_DV = 1'b0;
        wait_rx_dv(seen);
        check("chg_dv_seen", seen, 1);
        check("chg_byte", w_Rx_Byte, 8'h3C);
        step(4);
        check("chg_dv_count", dv_cnt - dv0, 1);

        // Reset in the middle of the data phase
        r_Tx_Byte = 8'h00;
        r_Tx_DV = 1'b1;
        step(1);
        r_Tx_DV = 1'b0;
        step(3);
        check("mid_line_low", w_Tx_Serial, 0);
        check("mid_active", w_Tx_Active, 1);
        #2 r_Reset = 1'b1;
        #1;
        check("mrst_tx_serial", w_Tx_Serial, 1);
        check("mrst_tx_active", w_Tx_Active, 0);
        check("mrst_tx_done", w_Tx_Done, 0);
        check("mrst_rx_dv", w_Rx_DV, 0);
        check("mrst_rx_byte", w_Rx_Byte, 0);
        check("mrst_rx_err", w_Rx_Frame_Err, 0);
        step(1);
        r_Reset = 1'b0;
        dv0 = dv_cnt;
        err0 = err_cnt;
        done0 = done_cnt;
        step(FRAME + 4);
        check("post_rst_line", w_Tx_Serial, 1);
        check("post_rst_dv", dv_cnt - dv0, 0);
        check("post_rst_err", err_cnt - err0, 0);
        check("post_rst_done", done_cnt - done0, 0);

`ifdef USRT_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1
        r_Tx_Byte = 8'h07;
        r_Tx_DV = 1'b1;
        step(1);
        r_Tx_DV = 1'b0;
        step(DATA_BITS + 1);
        check("par_bit", w_Tx_Serial, 1);
        wait_rx_dv(seen);
        check("par_dv_seen", seen, 1);
        check("par_byte", w_Rx_Byte, 8'h07);
        r_Loop = 1'b0;
        r_Rx_Drive = 1'b1;
        step(2);
        dv0 = dv_cnt;
        err0 = err_cnt;
        send_direct(8'h07, 1'b0, 1'b1);
        check("par_err_pulse", w_Rx_Frame_Err, 1);
        step(3);
        check("par_err_count", err_cnt - err0, 1);
        check("par_err_no_dv", dv_cnt - dv0, 0);
        check("par_err_byte", w_Rx_Byte, 8'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
